cp0_exc_unit: RTL and testbench

Coprocessor-0 exception endpoint of the P7 pipeline: it consumes the exception flags raised by the execute stage (Ov, AdEL, AdES) and the rest of the pipeline, already encoded as a single ExcCode, together with external hardware interrupts. It decides whether to take a trap, latches SR/Cause/EPC, and serves mfc0/mtc0/eret. It sits beside the M stage, the macro-PC commit point; its `Req` output flushes the pipeline and redirects fetch to the handler.

---
 rtl/cp0_exc_unit.sv | 107 ++++++++++
 tb/tb_cp0_exc_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: coprocessor-0 exception endpoint beside the M stage.
// Decides whether to trap (interrupt or synchronous exception), latches
// SR/Cause/EPC on a trap, and serves mfc0 reads, mtc0 writes and eret.
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   en             mtc0 write strobe
//   CP0Add         register number for mfc0/mtc0
//   CP0In          mtc0 write data
//   CP0Out         mfc0 read data (combinational)
//   VPC            PC of the instruction at M
//   BDIn           instruction at M sits in a branch delay slot
//   ExcCodeIn      encoded exception of the M instruction, 0 = none
//   HWInt          level-sensitive external interrupt lines
//   EXLClr         eret at M
//   EPCOut         current EPC register
//   Req            take a trap this cycle (combinational)
module cp0_exc_unit #(
  parameter logic [31:0] PRID = 32'h0000_0701
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  output logic [31:0] CP0Out,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] EPCOut,
  output logic        Req
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // Architectural state: only the implemented fields are stored.
  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;

  // Trap decision; EXL blocks both sources so a handler is never re-entered.
  always_comb begin
    int_req = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
    exc_req = (ExcCodeIn != 5'd0) & ~sr_exl;
    Req     = (int_req | exc_req) & ~reset;
  end

  // mfc0 read mux; unimplemented bits and registers read as zero.
  always_comb begin
    CP0Out = 32'h0;
    unique case (CP0Add)
      ADDR_SR:    CP0Out = {16'h0, sr_im, 8'h0, sr_exl, sr_ie};
      ADDR_CAUSE: CP0Out = {cause_bd, 15'h0, cause_ip, 3'h0, cause_exc, 2'h0};
      ADDR_EPC:   CP0Out = epc;
      ADDR_PRID:  CP0Out = PRID;
      default:    CP0Out = 32'h0;
    endcase
  end

  assign EPCOut = epc;

  // State update: trap capture beats mtc0; eret clears EXL after any SR write.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= 6'h0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= 6'h0;
      cause_exc <= 5'h0;
      epc       <= 32'h0;
    end else begin
      cause_ip <= HWInt;
      if (Req) begin
        sr_exl    <= 1'b1;
        cause_bd  <= BDIn;
        cause_exc <= int_req ? 5'd0 : ExcCodeIn;
        epc       <= BDIn ? (VPC - 32'd4) : VPC;
      end else begin
        if (en) begin
          if (CP0Add == ADDR_SR) begin
            sr_im  <= CP0In[15:10];
            sr_exl <= CP0In[1];
            sr_ie  <= CP0In[0];
          end else if (CP0Add == ADDR_EPC) begin
            epc <= CP0In;
          end
        end
        if (EXLClr) begin
          sr_exl <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb_cp0_exc_unit: directed self-checking bench for cp0_exc_unit.
// Expected values are queued when a step is driven and popped in order as
// the corresponding DUT output is sampled.
module tb_cp0_exc_unit;

  logic        clk;
  logic        reset;
  logic        en;
  logic [4:0]  CP0Add;
  logic [31:0] CP0In;
  logic [31:0] CP0Out;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] EPCOut;
  logic        Req;

  int total = 0;
  int bad   = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  cp0_exc_unit #(.PRID(32'h0000_0701)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .CP0Add    (CP0Add),
    .CP0In     (CP0In),
    .CP0Out    (CP0Out),
    .VPC       (VPC),
    .BDIn      (BDIn),
    .ExcCodeIn (ExcCodeIn),
    .HWInt     (HWInt),
    .EXLClr    (EXLClr),
    .EPCOut    (EPCOut),
    .Req       (Req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  // Inputs change #1 after the rising edge; samples are taken between edges.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rdchk(input logic [4:0] a);
    CP0Add = a;
    #1;
    pop_chk(CP0Out);
  endtask

  task automatic reqchk();
    #1;
    pop_chk({31'h0, Req});
  endtask

  task automatic epcchk();
    #1;
    pop_chk(EPCOut);
  endtask

  task automatic eret();
    EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; CP0Add = 5'd0; CP0In = 32'h0; VPC = 32'h0;
    BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'h0; EXLClr = 1'b0;
    step();

    // Reset held with a pending exception: no trap.
    ExcCodeIn = 5'd12;
    push("rst_req", 32'h0); reqchk();
    step();
    reset = 1'b0; ExcCodeIn = 5'd0;
    push("rst_sr", 32'h0); push("rst_cause", 32'h0);
    push("rst_epc", 32'h0); push("rst_prid", 32'h0000_0701);
    rdchk(5'd12); rdchk(5'd13); epcchk(); rdchk(5'd15);

    // Ov trap, not in a delay slot.
    ExcCodeIn = 5'd12; VPC = 32'h0000_3010;
    push("ov_req", 32'h1); reqchk();
    push("ov_epc", 32'h0000_3010); push("ov_cause", 32'h0000_0030);
    push("ov_sr", 32'h0000_0002); push("ov_req_held", 32'h0);
    step();
    epcchk(); rdchk(5'd13); rdchk(5'd12); reqchk();
    ExcCodeIn = 5'd0;
    eret();
    push("eret_sr", 32'h0); rdchk(5'd12);

    // AdES in a delay slot: EPC points at the branch.
    ExcCodeIn = 5'd5; VPC = 32'h0000_3008; BDIn = 1'b1;
    push("ades_req", 32'h1); reqchk();
    push("ades_epc", 32'h0000_3004); push("ades_cause", 32'h8000_0014);
    step();
    ExcCodeIn = 5'd0; BDIn = 1'b0;
    epcchk(); rdchk(5'd13);
    eret();

    // Misaligned AdEL in a delay slot near zero: EPC wraps, no masking.
    ExcCodeIn = 5'd4; VPC = 32'h0000_0002; BDIn = 1'b1;
    push("wrap_epc", 32'hFFFF_FFFE); push("wrap_cause", 32'h8000_0010);
    step();
    ExcCodeIn = 5'd0; BDIn = 1'b0;
    epcchk(); rdchk(5'd13);
    eret();

    // mtc0 SR; same-cycle mfc0 returns the old value.
    en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0401;
    push("mfc0_old", 32'h0); #1; pop_chk(CP0Out);
    step();
    en = 1'b0;
    push("sr_wr", 32'h0000_0401); rdchk(5'd12);

    // Interrupt beats a simultaneous AdEL.
    HWInt = 6'b000001; ExcCodeIn = 5'd4; VPC = 32'h0000_3040;
    push("prio_req", 32'h1); reqchk();
    step();
    ExcCodeIn = 5'd8;
    push("prio_cause", 32'h0000_0400); push("prio_epc", 32'h0000_3040);
    push("prio_sr", 32'h0000_0403); push("exl_block_req", 32'h0);
    rdchk(5'd13); epcchk(); rdchk(5'd12); reqchk();

    // eret with the interrupt still pending re-raises Req at once.
    ExcCodeIn = 5'd0; VPC = 32'h0000_3044;
    eret();
    push("pend_sr", 32'h0000_0401); push("pend_req", 32'h1);
    rdchk(5'd12); reqchk();
    step();
    HWInt = 6'h0;
    push("pend_epc", 32'h0000_3044); epcchk();
    eret();

    // IE=0 masks the interrupt while IP still tracks the line.
    en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0400;
    step();
    en = 1'b0; HWInt = 6'b000001;
    push("mask_req", 32'h0); reqchk();
    step();
    push("mask_ip", 32'h0000_0400); push("mask_req_still", 32'h0);
    rdchk(5'd13); reqchk();

    // Setting IE takes effect the cycle after the write.
    en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0401;
    push("ie_wr_req", 32'h0); reqchk();
    step();
    en = 1'b0; VPC = 32'h0000_3050;
    push("ie_req", 32'h1); reqchk();
    step();

    // eret coinciding with an mtc0 to SR: EXL forced to 0, rest written.
    HWInt = 6'h0; en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0C03;
    EXLClr = 1'b1;
    step();
    en = 1'b0; EXLClr = 1'b0;
    push("eret_mtc0_sr", 32'h0000_0C01); rdchk(5'd12);

    // mtc0 EPC: no same-cycle forwarding, visible next cycle.
    en = 1'b1; CP0Add = 5'd14; CP0In = 32'h0000_3100;
    push("epc_nofwd", 32'h0000_3050); epcchk();
    step();
    en = 1'b0;
    push("epc_wr", 32'h0000_3100); epcchk();

    // Cause and PRId are read-only; unimplemented register reads 0.
    en = 1'b1; CP0Add = 5'd13; CP0In = 32'hFFFF_FFFF;
    step();
    CP0Add = 5'd15; CP0In = 32'h0;
    step();
    en = 1'b0;
    push("cause_ro", 32'h0); push("prid_ro", 32'h0000_0701);
    push("rsvd_rd", 32'h0);
    rdchk(5'd13); rdchk(5'd15); rdchk(5'd7);

    // mtc0 EPC lost to a same-cycle RI trap.
    en = 1'b1; CP0Add = 5'd14; CP0In = 32'hDEAD_BEEF;
    ExcCodeIn = 5'd10; VPC = 32'h0000_3020;
    push("sup_req", 32'h1); reqchk();
    step();
    en = 1'b0; ExcCodeIn = 5'd0;
    push("sup_epc", 32'h0000_3020); push("sup_cause", 32'h0000_0028);
    push("sup_sr", 32'h0000_0C03);
    epcchk(); rdchk(5'd13); rdchk(5'd12);
    eret();

    // Reset during a would-be trap: reset wins, state clears.
    reset = 1'b1; ExcCodeIn = 5'd12; HWInt = 6'b000001;
    push("rst_trap_req", 32'h0); reqchk();
    step();
    reset = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'h0;
    push("rst2_sr", 32'h0); push("rst2_cause", 32'h0);
    push("rst2_epc", 32'h0); push("rst2_req", 32'h0);
    rdchk(5'd12); rdchk(5'd13); epcchk(); reqchk();

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
